cipher_chain_ctrl: RTL
======================

Name: cipher_chain_ctrl

Overview:
- Block-mode front end that sits directly upstream of the AES cipher core and drives its CipherBus master signals.
- Buffers a stream of 128-bit blocks and issues them to the core one at a time, honouring the core's o_ready / i_data_valid / o_data_valid handshake.
- Applies ECB or CBC chaining and presents results on a valid/ready output stream.
- Key expansion stays on KeyBus and is outside this block; the key is loaded before any traffic.

Parameters:
DEPTH, 4, input FIFO depth in 128-bit blocks (power of 2, ≥2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
i_mode  input  1  chaining mode, 0=ECB, 1=CBC; latched on i_iv_load
i_ende  input  1  direction, 0=encrypt, 1=decrypt; latched on i_iv_load
i_iv  input  128  initialisation vector
i_iv_load  input  1  one-cycle strobe: load IV, mode and direction
s_data  input  128  input block (plaintext or ciphertext)
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept (count < DEPTH)
m_data  output  128  result block
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts m_data
core_i_data  output  128  to core i_data
core_i_data_valid  output  1  to core i_data_valid, one-cycle pulse
core_i_ende  output  1  to core i_ende (latched direction)
core_i_enable  output  1  to core i_enable
core_o_ready  input  1  core idle
core_o_data  input  128  core result
core_o_data_valid  input  1  core result valid
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (reset=0 at clk edge):
  - All outputs 0; FIFO empty; chain register 0; mode=ECB; ende=0; FSM=IDLE.
  - Any in-flight block is abandoned. Reset mid-operation needs no drain; a later core_o_data_valid is ignored outside WAIT.
- core_i_enable=1 every cycle out of reset. core_i_ende = latched ende.
- FIFO:
  - Push when s_valid && s_ready.
  - s_ready is registered from count; no same-cycle pass-through when full.
  - Pop only in ISSUE. Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- i_iv_load:
  - Accepted only when FSM=IDLE and FIFO empty; otherwise ignored, with no state change.
  - Loads chain←i_iv, mode←i_mode, ende←i_ende.
  - If it coincides with an s_valid push, both are accepted and the block uses the new IV.
- FSM, one block in flight:
  - IDLE: FIFO non-empty && core_o_ready → ISSUE.
  - ISSUE (one cycle):
    - core_i_data_valid=1.
    - core_i_data = head^chain when (CBC && encrypt), otherwise head.
    - Save head into prev register; pop FIFO; → WAIT.
  - WAIT: hold until core_o_data_valid, then capture:
    - ECB: result = core_o_data.
    - CBC encrypt: result = core_o_data; chain←core_o_data.
    - CBC decrypt: result = core_o_data^chain; chain←prev.
    - → OUT.
  - OUT: m_valid=1 with m_data=result, held stable until m_ready; on handshake → IDLE.
- Latency:
  - Block pushed at edge T into an empty FIFO with core ready: core_i_data_valid is high in cycle T+2.
  - m_valid rises the cycle after core_o_data_valid.
  - Back-pressure on m_ready stalls the FSM; the FIFO keeps filling until full.
- XORs are full 128-bit; no arithmetic carries.

Test Plan:
1. Identity core stub (o_data=i_data, 3-cycle latency), ECB encrypt, push A=0x0011…ff, B=0xffee…00 → m_data A then B in order; core_i_data_valid pulses exactly twice, one cycle each.
2. Stub core, CBC encrypt, IV=0x000102…0f, push P=0x6bc1bee22e409f96e93d7e117393172a → core_i_data = P^IV; m_data = P^IV; chain updated to P^IV.
3. Real AES-128 core, key 2b7e151628aed2a6abf7158809cf4f3c, CBC encrypt, IV 000102030405060708090a0b0c0d0e0f, push 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 → 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2.
4. Same core and key, CBC decrypt of those two ciphertexts with the same IV → original two plaintexts in order.
5. DEPTH=4, m_ready=0, push 6 blocks → s_ready drops after 5 accepted (4 in FIFO + 1 in flight); m_data stable while stalled; raising m_ready drains all 5 in order.
6. Pulse i_iv_load while busy=1 → ignored, chain unchanged. Assert reset=0 in WAIT → all outputs 0, busy=0, and a late core_o_data_valid produces no m_valid.

Source files
------------

// File: rtl/cipher_chain_ctrl.sv
// cipher_chain_ctrl
//   Block-mode front end for the AES cipher core. It buffers incoming 128-bit
//   blocks in a small FIFO and issues them to the core one at a time. ECB or
//   CBC chaining is applied around the core, and results are presented on a
//   valid/ready output stream.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-low reset
//   i_mode, i_ende       chaining mode (0=ECB, 1=CBC) and direction (0=enc, 1=dec)
//   i_iv, i_iv_load      IV value and one-cycle load strobe (IV, mode, direction)
//   s_data/valid/ready   input block stream
//   m_data/valid/ready   result block stream
//   core_*               CipherBus master towards the cipher core
//   busy                 FIFO non-empty or a block in flight
module cipher_chain_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_mode,
  input  logic         i_ende,
  input  logic [127:0] i_iv,
  input  logic         i_iv_load,
  input  logic [127:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] core_i_data,
  output logic         core_i_data_valid,
  output logic         core_i_ende,
  output logic         core_i_enable,
  input  logic         core_o_ready,
  input  logic [127:0] core_o_data,
  input  logic         core_o_data_valid,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t state, state_next;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          s_ready_q, enable_q;
  logic          mode, ende;
  logic [127:0]  chain, prev, result, head;
  logic          push, pop, iv_acc, capture;

  assign head    = mem[rd_ptr];
  assign push    = s_valid && s_ready_q;
  assign pop     = (state == ISSUE);
  // IV/mode/direction may only change with nothing buffered or in flight,
  // so no queued block ever sees a half-switched context.
  assign iv_acc  = i_iv_load && (state == IDLE) && (count == '0);
  assign capture = (state == WAIT) && core_o_data_valid;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and core/output strobes
  always_comb begin
    state_next        = state;
    core_i_data_valid = 1'b0;
    core_i_data       = '0;
    m_valid           = 1'b0;
    case (state)
      IDLE: if (count != '0 && core_o_ready) state_next = ISSUE;
      ISSUE: begin
        core_i_data_valid = 1'b1;
        // Only CBC encryption whitens the block before the core; CBC
        // decryption applies the chain after the core instead.
        core_i_data       = (mode && !ende) ? (head ^ chain) : head;
        state_next        = WAIT;
      end
      WAIT: if (core_o_data_valid) state_next = OUT;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_ready_q <= 1'b0;
      enable_q  <= 1'b0;
      mode      <= 1'b0;
      ende      <= 1'b0;
      chain     <= '0;
      prev      <= '0;
      result    <= '0;
    end else begin
      enable_q  <= 1'b1;
      count     <= count_next;
      // Registered from the next occupancy, so a full FIFO never accepts.
      s_ready_q <= (count_next < CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        prev   <= head;
      end
      if (iv_acc) begin
        chain <= i_iv;
        mode  <= i_mode;
        ende  <= i_ende;
      end
      if (capture) begin
        if (mode && ende) begin
          // CBC decrypt: unchain with the previous ciphertext, then that
          // ciphertext (saved at issue) becomes the next chain value.
          result <= core_o_data ^ chain;
          chain  <= prev;
        end else begin
          result <= core_o_data;
          if (mode) chain <= core_o_data;
        end
      end
    end
  end

  assign s_ready       = s_ready_q;
  assign m_data        = result;
  assign core_i_ende   = ende;
  assign core_i_enable = enable_q;
  assign busy          = (count != '0) || (state != IDLE);

endmodule
